// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared action/state types and attack frame constants for the fighter animator
package fighter_pkg;

  typedef enum logic [2:0] {
    ACT_IDLE        = 3'd0,
    ACT_WALK        = 3'd1,
    ACT_CROUCH      = 3'd2,
    ACT_PUNCH       = 3'd3,
    ACT_KICK        = 3'd4,
    ACT_CROUCHPUNCH = 3'd5
  } action_t;

  typedef enum logic [1:0] {
    ST_POSE,
    ST_WINDUP,
    ST_ACTIVE,
    ST_RECOVER
  } anim_state_t;

  localparam int ATTACK_FRAMES = 3;
  localparam logic [1:0] FRAME_WINDUP  = 2'd0;
  localparam logic [1:0] FRAME_ACTIVE  = 2'd1;
  localparam logic [1:0] FRAME_RECOVER = 2'(ATTACK_FRAMES - 1);

  function automatic logic is_attack(input action_t a);
    return (a == ACT_PUNCH) || (a == ACT_KICK) || (a == ACT_CROUCHPUNCH);
  endfunction

  // Codes 6 and 7 have no sprite ROM behind them, so they fall back to idle.
  function automatic action_t decode_action(input logic [2:0] code);
    return (code > 3'd5) ? ACT_IDLE : action_t'(code);
  endfunction

  function automatic action_t return_pose(input action_t a);
    return (a == ACT_CROUCHPUNCH) ? ACT_CROUCH : ACT_IDLE;
  endfunction

endpackage

// File: rtl/anim_hold_counter.sv
// rtl/anim_hold_counter.sv - divides frame_tick by HOLD_TICKS; expire pulses on the last tick of a frame
module anim_hold_counter #(
  parameter int HOLD_TICKS = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [5:0] LAST = 6'(HOLD_TICKS - 1);

  logic [5:0] count;

  assign expire = tick && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 6'd0;
    end else if (clear) begin
      count <= 6'd0;
    end else if (tick) begin
      count <= expire ? 6'd0 : count + 6'd1;
    end
  end

endmodule

// File: rtl/fighter_anim_controller.sv
// rtl/fighter_anim_controller.sv - per-fighter sprite/frame sequencer
// Optional ANIM_ATTACK_CANCEL_EN: accept requests during RECOVER (attack cancel / return-pose override).
module fighter_anim_controller
  import fighter_pkg::*;
#(
  parameter int HOLD_TICKS  = 6,
  parameter int WALK_FRAMES = 4
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       act_valid,
  output logic       act_ready,
  input  logic [2:0] act_code,
  input  logic       facing_left,
  output logic [2:0] sprite_sel,
  output logic [1:0] frame_idx,
  output logic       mirror,
  output logic       busy,
  output logic       hit_active
);

  localparam logic [1:0] WALK_LAST = 2'(WALK_FRAMES - 1);

  anim_state_t state, state_n;
  action_t     sprite, sprite_n, pending, pending_n, eff;
  logic [1:0]  frame, frame_n;
  logic        mirror_q, mirror_n;
  logic        accept, expire, clear;

  anim_hold_counter #(.HOLD_TICKS(HOLD_TICKS)) u_hold (
    .clk    (vga_clk),
    .reset  (reset),
    .clear  (clear),
    .tick   (frame_tick),
    .expire (expire)
  );

`ifdef ANIM_ATTACK_CANCEL_EN
  assign act_ready = !reset && ((state == ST_POSE) || (state == ST_RECOVER));
`else
  assign act_ready = !reset && (state == ST_POSE);
`endif

  assign accept = act_valid && act_ready;
  // A request arriving on the tick cycle itself is applied on that tick.
  assign eff    = accept ? decode_action(act_code) : pending;

  always_comb begin
    state_n   = state;
    sprite_n  = sprite;
    frame_n   = frame;
    mirror_n  = mirror_q;
    pending_n = eff;
    if (frame_tick) begin
      case (state)
        ST_POSE: begin
          mirror_n = facing_left;
          if (is_attack(eff)) begin
            state_n   = ST_WINDUP;
            sprite_n  = eff;
            frame_n   = FRAME_WINDUP;
            pending_n = return_pose(eff);
          end else if (eff != sprite) begin
            sprite_n = eff;
            frame_n  = 2'd0;
          end else if (sprite == ACT_WALK && expire) begin
            frame_n = (frame == WALK_LAST) ? 2'd0 : frame + 2'd1;
          end
        end
        ST_WINDUP: begin
          if (expire) begin
            state_n = ST_ACTIVE;
            frame_n = FRAME_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (expire) begin
            state_n = ST_RECOVER;
            frame_n = FRAME_RECOVER;
          end
        end
        ST_RECOVER: begin
`ifdef ANIM_ATTACK_CANCEL_EN
          if (is_attack(eff)) begin
            state_n   = ST_WINDUP;
            sprite_n  = eff;
            frame_n   = FRAME_WINDUP;
            mirror_n  = facing_left;
            pending_n = return_pose(eff);
          end else
`endif
          if (expire) begin
            // pending already holds the return pose chosen at attack entry
            state_n  = ST_POSE;
            sprite_n = eff;
            frame_n  = 2'd0;
          end
        end
        default: state_n = ST_POSE;
      endcase
    end
  end

  assign clear = frame_tick && ((state_n != state) || (sprite_n != sprite));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state    <= ST_POSE;
      sprite   <= ACT_IDLE;
      pending  <= ACT_IDLE;
      frame    <= 2'd0;
      mirror_q <= 1'b0;
    end else begin
      state    <= state_n;
      sprite   <= sprite_n;
      pending  <= pending_n;
      frame    <= frame_n;
      mirror_q <= mirror_n;
    end
  end

  assign sprite_sel = sprite;
  assign frame_idx  = frame;
  assign mirror     = mirror_q;
  assign busy       = (state != ST_POSE);
  assign hit_active = (state == ST_ACTIVE);

endmodule
